// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC selection, fetch handshake, stall-deferred redirects,
// exceptions and halt. Define PC_ALIGN_CHECK_EN to trap misaligned redirect targets.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc_cur,
    output logic [31:0] next_pc,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exc,
    input  logic        eret,
    input  logic        halt,
    output logic [31:0] epc,
    output logic        halted,
    output logic        misalign
);

    typedef enum logic [1:0] {StBoot, StFetch, StHalted} state_e;

    // Redirect priority codes; 0 means "no redirect" so pend_prio_q doubles as a valid flag.
    localparam logic [1:0] PrioNone   = 2'd0;
    localparam logic [1:0] PrioJump   = 2'd1;
    localparam logic [1:0] PrioBranch = 2'd2;
    localparam logic [1:0] PrioEret   = 2'd3;

    state_e      state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic [1:0]  pend_prio_q, pend_prio_d;
    logic [31:0] pend_target_q, pend_target_d;

    logic [1:0]  new_prio;
    logic [31:0] new_target;
    logic [1:0]  eff_prio;
    logic [31:0] eff_target;
    logic        eff_misaligned;
    logic        handshake;

    always_comb begin
        new_prio   = PrioNone;
        new_target = 32'h0;
        if (eret) begin
            new_prio   = PrioEret;
            new_target = epc_q;
        end else if (branch_taken) begin
            new_prio   = PrioBranch;
            new_target = branch_target;
        end else if (jump) begin
            new_prio   = PrioJump;
            new_target = jump_target;
        end
`ifndef PC_ALIGN_CHECK_EN
        new_target[1:0] = 2'b00;
`endif
        // A latched redirect yields only to a strictly higher-priority new one.
        if (new_prio > pend_prio_q) begin
            eff_prio   = new_prio;
            eff_target = new_target;
        end else begin
            eff_prio   = pend_prio_q;
            eff_target = pend_target_q;
        end
`ifdef PC_ALIGN_CHECK_EN
        eff_misaligned = (eff_target[1:0] != 2'b00);
`else
        eff_misaligned = 1'b0;
`endif
    end

    always_comb begin
        state_d       = state_q;
        epc_d         = epc_q;
        pend_prio_d   = pend_prio_q;
        pend_target_d = pend_target_q;
        next_pc       = pc_cur;
        imem_req      = 1'b0;
        instr_valid   = 1'b0;
        halted        = 1'b0;
        misalign      = 1'b0;
        handshake     = 1'b0;

        unique case (state_q)
            StBoot: begin
                next_pc = RESET_VECTOR;
                state_d = StFetch;
            end
            StFetch: begin
                imem_req  = !stall;
                handshake = !stall && imem_ready;
                if (exc) begin
                    next_pc     = EXC_VECTOR;
                    epc_d       = pc_cur;
                    pend_prio_d = PrioNone;
                end else if (eff_prio != PrioNone) begin
                    if (stall) begin
                        pend_prio_d   = eff_prio;
                        pend_target_d = eff_target;
                    end else if (eff_misaligned) begin
                        next_pc     = EXC_VECTOR;
                        epc_d       = pc_cur;
                        misalign    = 1'b1;
                        pend_prio_d = PrioNone;
                    end else begin
                        next_pc     = eff_target;
                        pend_prio_d = PrioNone;
                    end
                end else if (handshake) begin
                    instr_valid = 1'b1;
                    next_pc     = pc_cur + 32'd4;
                    if (halt) begin
                        state_d = StHalted;
                    end
                end
            end
            StHalted: begin
                halted = 1'b1;
                if (exc) begin
                    next_pc     = EXC_VECTOR;
                    epc_d       = pc_cur;
                    pend_prio_d = PrioNone;
                    state_d     = StFetch;
                end
            end
            default: state_d = StBoot;
        endcase

        if (!reset) begin
            next_pc     = RESET_VECTOR;
            imem_req    = 1'b0;
            instr_valid = 1'b0;
            halted      = 1'b0;
            misalign    = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= StBoot;
            epc_q         <= 32'h0;
            pend_prio_q   <= PrioNone;
            pend_target_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            epc_q         <= epc_d;
            pend_prio_q   <= pend_prio_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign epc = epc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; models the PC register that loads next_pc every edge.
module tb_pc_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pc_q;
    logic [31:0] next_pc;
    logic        imem_req;
    logic        imem_ready;
    logic        instr_valid;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        exc;
    logic        eret;
    logic        halt;
    logic [31:0] epc;
    logic        halted;
    logic        misalign;

    int tests = 0;
    int fails = 0;

    pc_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .pc_cur       (pc_q),
        .next_pc      (next_pc),
        .imem_req     (imem_req),
        .imem_ready   (imem_ready),
        .instr_valid  (instr_valid),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .exc          (exc),
        .eret         (eret),
        .halt         (halt),
        .epc          (epc),
        .halted       (halted),
        .misalign     (misalign)
    );

    always #5 clock = ~clock;

    always @(posedge clock) pc_q <= next_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then leave 1 time unit for inputs to be driven before checks.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Outputs are combinational: settle after input changes before sampling.
    task automatic settle();
        #1;
    endtask

    initial begin
        pc_q          = 32'hDEAD_BEEF;
        reset         = 1'b0;
        imem_ready    = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump          = 1'b0;
        jump_target   = 32'h0;
        exc           = 1'b0;
        eret          = 1'b0;
        halt          = 1'b0;

        // Reset for three edges.
        tick(); tick(); tick();
        chk("rst_next_pc", next_pc, 32'h0);
        chk("rst_imem_req", {31'b0, imem_req}, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'h0);
        chk("rst_misalign", {31'b0, misalign}, 32'h0);
        chk("rst_epc", epc, 32'h0);

        reset = 1'b1; settle();
        chk("boot_next_pc", next_pc, 32'h0);
        chk("boot_imem_req", {31'b0, imem_req}, 32'h0);

        tick();
        chk("f0_req", {31'b0, imem_req}, 32'h1);
        chk("f0_valid", {31'b0, instr_valid}, 32'h1);
        chk("f0_next", next_pc, 32'h4);
        tick();
        chk("f4_next", next_pc, 32'h8);
        chk("f4_valid", {31'b0, instr_valid}, 32'h1);
        tick();
        chk("f8_next", next_pc, 32'hC);
        tick();
        chk("fc_next", next_pc, 32'h10);

        // Memory wait at 0x10.
        tick();
        imem_ready = 1'b0; settle();
        chk("wait1_next", next_pc, 32'h10);
        chk("wait1_valid", {31'b0, instr_valid}, 32'h0);
        chk("wait1_req", {31'b0, imem_req}, 32'h1);
        tick();
        chk("wait2_next", next_pc, 32'h10);
        chk("wait2_valid", {31'b0, instr_valid}, 32'h0);
        tick();
        imem_ready = 1'b1; settle();
        chk("ready_next", next_pc, 32'h14);
        chk("ready_valid", {31'b0, instr_valid}, 32'h1);

        // Branch during stall at 0x14.
        tick();
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h200; settle();
        chk("stbr_req", {31'b0, imem_req}, 32'h0);
        chk("stbr_next", next_pc, 32'h14);
        chk("stbr_valid", {31'b0, instr_valid}, 32'h0);
        tick();
        branch_taken = 1'b0; branch_target = 32'h0; settle();
        for (int i = 0; i < 3; i++) begin
            chk("st_hold_next", next_pc, 32'h14);
            chk("st_hold_req", {31'b0, imem_req}, 32'h0);
            if (i < 2) tick();
        end
        tick();
        stall = 1'b0; settle();
        chk("strel_next", next_pc, 32'h200);
        chk("strel_valid", {31'b0, instr_valid}, 32'h0);
        chk("strel_req", {31'b0, imem_req}, 32'h1);
        tick();
        chk("br_land_next", next_pc, 32'h204);
        chk("br_land_valid", {31'b0, instr_valid}, 32'h1);

        // Jump to 0x40, then exc+branch together.
        tick();
        jump = 1'b1; jump_target = 32'h40; settle();
        chk("j40_next", next_pc, 32'h40);
        chk("j40_valid", {31'b0, instr_valid}, 32'h0);
        tick();
        jump = 1'b0; exc = 1'b1; branch_taken = 1'b1; branch_target = 32'h300; settle();
        chk("exc_next", next_pc, 32'h80);
        chk("exc_valid", {31'b0, instr_valid}, 32'h0);
        tick();
        exc = 1'b0; branch_taken = 1'b0; settle();
        chk("exc_epc", epc, 32'h40);
        chk("exc_land_next", next_pc, 32'h84);
        eret = 1'b1; settle();
        chk("eret_next", next_pc, 32'h40);
        chk("eret_valid", {31'b0, instr_valid}, 32'h0);
        tick();
        eret = 1'b0; settle();
        chk("eret_land_next", next_pc, 32'h44);

        // Pending overwrite: higher priority replaces, lower does not.
        stall = 1'b1; jump = 1'b1; jump_target = 32'h500; settle();
        chk("pj_next", next_pc, 32'h40);
        tick();
        jump = 1'b0; branch_taken = 1'b1; branch_target = 32'h600; settle();
        tick();
        branch_taken = 1'b0; jump = 1'b1; jump_target = 32'h700; settle();
        chk("pj_hold_next", next_pc, 32'h40);
        tick();
        jump = 1'b0; stall = 1'b0; settle();
        chk("pend_prio_next", next_pc, 32'h600);

        // Halt at 0x30.
        tick();
        jump = 1'b1; jump_target = 32'h30; settle();
        tick();
        jump = 1'b0; halt = 1'b1; settle();
        chk("halt_valid", {31'b0, instr_valid}, 32'h1);
        chk("halt_next", next_pc, 32'h34);
        tick();
        halt = 1'b0; settle();
        chk("hd_halted", {31'b0, halted}, 32'h1);
        chk("hd_req", {31'b0, imem_req}, 32'h0);
        chk("hd_next", next_pc, 32'h34);
        tick();
        branch_taken = 1'b1; branch_target = 32'h900; settle();
        chk("hd_br_ignored", next_pc, 32'h34);
        branch_taken = 1'b0; exc = 1'b1; settle();
        chk("wake_next", next_pc, 32'h80);
        tick();
        exc = 1'b0; settle();
        chk("wake_halted", {31'b0, halted}, 32'h0);
        chk("wake_epc", epc, 32'h34);
        chk("wake_next_seq", next_pc, 32'h84);

        // Misaligned jump at 0x84.
        tick();
        jump = 1'b1; jump_target = 32'h102; settle();
`ifdef PC_ALIGN_CHECK_EN
        chk("mis_next", next_pc, 32'h80);
        chk("mis_pulse", {31'b0, misalign}, 32'h1);
`else
        chk("mis_next", next_pc, 32'h100);
        chk("mis_pulse", {31'b0, misalign}, 32'h0);
`endif
        tick();
        jump = 1'b0; settle();
        chk("mis_pulse_end", {31'b0, misalign}, 32'h0);
`ifdef PC_ALIGN_CHECK_EN
        chk("mis_epc", epc, 32'h84);
`else
        chk("mis_epc", epc, 32'h34);
`endif

        // Wrap at the top of the address space.
        jump = 1'b1; jump_target = 32'hFFFF_FFFC; settle();
        tick();
        jump = 1'b0; settle();
        chk("wrap_next", next_pc, 32'h0);
        chk("wrap_valid", {31'b0, instr_valid}, 32'h1);

        // Reset mid-handshake drops the fetch.
        imem_ready = 1'b0; reset = 1'b0; settle();
        chk("midrst_req", {31'b0, imem_req}, 32'h0);
        chk("midrst_next", next_pc, 32'h0);
        tick();
        chk("midrst_epc", epc, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
